// File: rtl/fpu_seq_pkg.sv
// rtl/fpu_seq_pkg.sv - fpu_seq states, tick constants and phase-to-output map
package fpu_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_F1, S_F2, S_F3, S_F4, S_F5, S_F6,
        S_F7, S_F8, S_F9, S_F10, S_F13, S_DONE
    } state_t;

    localparam logic [1:0] TICK0 = 2'd0;
    localparam logic [1:0] TICK1 = 2'd1;
    localparam logic [1:0] TICK2 = 2'd2;
    localparam int TICKS_PER_UCYCLE = 3;

    typedef struct packed {
        logic f2_;
        logic f4_;
        logic f5_;
        logic f6_;
        logic f7_;
        logic f8_;
        logic f10_;
        logic f9;
        logic f13;
        logic zero_f;
        logic fend;
    } phase_out_t;

    // Bit order: f2_ f4_ f5_ f6_ f7_ f8_ f10_ | f9 f13 zero_f fend
    localparam phase_out_t OUT_NONE = 11'b1111111_0000;
    localparam phase_out_t OUT_F1   = 11'b1111111_0010;
    localparam phase_out_t OUT_F2   = 11'b0111111_0000;
    localparam phase_out_t OUT_F4   = 11'b1011111_0000;
    localparam phase_out_t OUT_F5   = 11'b1101111_0000;
    localparam phase_out_t OUT_F6   = 11'b1110111_0000;
    localparam phase_out_t OUT_F7   = 11'b1111011_0000;
    localparam phase_out_t OUT_F8   = 11'b1111101_0000;
    localparam phase_out_t OUT_F10  = 11'b1111110_0000;
    localparam phase_out_t OUT_F9   = 11'b1111111_1000;
    localparam phase_out_t OUT_F13  = 11'b1111111_0100;
    localparam phase_out_t OUT_DONE = 11'b1111111_0001;

    function automatic phase_out_t phase_out(state_t s);
        case (s)
            S_F1:    return OUT_F1;
            S_F2:    return OUT_F2;
            S_F4:    return OUT_F4;
            S_F5:    return OUT_F5;
            S_F6:    return OUT_F6;
            S_F7:    return OUT_F7;
            S_F8:    return OUT_F8;
            S_F9:    return OUT_F9;
            S_F10:   return OUT_F10;
            S_F13:   return OUT_F13;
            S_DONE:  return OUT_DONE;
            default: return OUT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/fpu_seq_tick.sv
// rtl/fpu_seq_tick.sv - mod-3 micro-cycle tick counter producing the two F-PM strobes
import fpu_seq_pkg::*;

module fpu_seq_tick (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    output logic strob_fp,
    output logic strob2_fp,
    output logic ucycle_end
);

    localparam logic [1:0] LAST_TICK = 2'(TICKS_PER_UCYCLE - 1);

    logic [1:0] tick;

    // Held at tick0 while disabled so the first F1 micro-cycle starts aligned
    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            tick <= TICK0;
        end else if (tick == LAST_TICK) begin
            tick <= TICK0;
        end else begin
            tick <= tick + 2'd1;
        end
    end

    assign strob_fp   = en && (tick == TICK1);
    assign strob2_fp  = en && (tick == TICK2);
    assign ucycle_end = strob2_fp;

endmodule

// File: rtl/fpu_seq.sv
// rtl/fpu_seq.sv - FPU phase sequencer; optional watchdog under FPU_SEQ_WDOG_EN
import fpu_seq_pkg::*;

module fpu_seq #(
    parameter int WDOG_MAX = 127
) (
    input  logic __clk,
    input  logic clr_,
    input  logic puf,
    input  logic af_sf,
    input  logic nrf,
    input  logic ff,
    input  logic g,
    input  logic fic,
    input  logic ws,
    input  logic di,
    output logic f2_,
    output logic f4_,
    output logic f5_,
    output logic f6_,
    output logic f7_,
    output logic f8_,
    output logic f10_,
    output logic f9,
    output logic f13,
    output logic strob_fp,
    output logic strob2_fp,
    output logic _0_f,
    output logic fend,
    output logic wdog
);

    state_t     state;
    state_t     next_state;
    logic       tick_en;
    logic       ucycle_end;
    logic       wdog_hit;
    phase_out_t po;

    assign tick_en = (state != S_IDLE) && (state != S_DONE);

    fpu_seq_tick u_tick (
        .clk        (__clk),
        .resetn     (clr_),
        .en         (tick_en),
        .strob_fp   (strob_fp),
        .strob2_fp  (strob2_fp),
        .ucycle_end (ucycle_end)
    );

    always_ff @(posedge __clk) begin
        if (!clr_) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (puf) next_state = S_F1;
            S_DONE: if (!puf) next_state = S_IDLE;
            default: begin
                if (ucycle_end) begin
                    case (state)
                        S_F1:    next_state = S_F2;
                        S_F2:    next_state = af_sf ? S_F5 : S_F4;
                        S_F5:    next_state = g ? S_F3 : S_F8;
                        S_F8:    next_state = fic ? S_F8 : S_F6;
                        S_F4:    next_state = fic ? S_F4 : (nrf ? S_F13 : S_F9);
                        S_F9:    next_state = S_F6;
                        S_F6:    next_state = S_F7;
                        S_F7:    next_state = S_F10;
                        S_F10:   next_state = ws ? S_F6 : (ff ? S_F13 : S_F3);
                        S_F13:   next_state = S_F3;
                        S_F3:    next_state = S_DONE;
                        default: next_state = S_IDLE;
                    endcase
                    // Interrupt and watchdog both abort straight to the closing phase
                    if ((state != S_F3) && (di || wdog_hit)) begin
                        next_state = S_F3;
                    end
                end
            end
        endcase
    end

    assign po   = phase_out(state);
    assign f2_  = po.f2_;
    assign f4_  = po.f4_;
    assign f5_  = po.f5_;
    assign f6_  = po.f6_;
    assign f7_  = po.f7_;
    assign f8_  = po.f8_;
    assign f10_ = po.f10_;
    assign f9   = po.f9;
    assign f13  = po.f13;
    assign _0_f = po.zero_f;
    assign fend = po.fend;

`ifdef FPU_SEQ_WDOG_EN
    localparam int CW = $clog2(WDOG_MAX + 1);
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_MAX - 1);
    localparam logic [CW-1:0] WDOG_TOP  = CW'(WDOG_MAX);

    logic [CW-1:0] ucycle_cnt;
    logic          wdog_q;

    // Counts completed micro-cycles since F1; hit fires on the one that reaches WDOG_MAX
    assign wdog_hit = ucycle_end && (state != S_F3) && (ucycle_cnt == WDOG_LAST);

    always_ff @(posedge __clk) begin
        if (!clr_) begin
            ucycle_cnt <= '0;
            wdog_q     <= 1'b0;
        end else if (next_state == S_F1) begin
            ucycle_cnt <= '0;
            wdog_q     <= 1'b0;
        end else begin
            if (ucycle_end && (ucycle_cnt != WDOG_TOP)) begin
                ucycle_cnt <= ucycle_cnt + 1'b1;
            end
            if (wdog_hit) begin
                wdog_q <= 1'b1;
            end
        end
    end

    assign wdog = wdog_q;
`else
    logic [31:0] unused_wdog_max;
    assign unused_wdog_max = WDOG_MAX;
    assign wdog_hit        = 1'b0;
    assign wdog            = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_seq.sv
// tb/tb_fpu_seq.sv - self-checking bench for fpu_seq against a phase-level reference model
module tb_fpu_seq;

    localparam int WDOG_MAX = 8;
`ifdef FPU_SEQ_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef enum int {
        P_IDLE, P_F1, P_F2, P_F3, P_F4, P_F5, P_F6,
        P_F7, P_F8, P_F9, P_F10, P_F13, P_DONE
    } ph_t;

    typedef struct packed {
        logic af_sf;
        logic nrf;
        logic ff;
        logic g;
        logic fic;
        logic ws;
        logic di;
    } in_t;

    logic clk = 1'b0;
    logic clr_, puf, af_sf, nrf, ff, g, fic, ws, di;
    logic f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13;
    logic strob_fp, strob2_fp, _0_f, fend, wdog;

    int   checks   = 0;
    int   failures = 0;
    logic wd_exp   = 1'b0;
    bit   ws_used;
    in_t  script[$];
    ph_t  visited[$];

    always #5 clk = ~clk;

    fpu_seq #(.WDOG_MAX(WDOG_MAX)) dut (
        .__clk(clk), .clr_(clr_), .puf(puf), .af_sf(af_sf), .nrf(nrf), .ff(ff),
        .g(g), .fic(fic), .ws(ws), .di(di),
        .f2_(f2_), .f4_(f4_), .f5_(f5_), .f6_(f6_), .f7_(f7_), .f8_(f8_), .f10_(f10_),
        .f9(f9), .f13(f13), .strob_fp(strob_fp), .strob2_fp(strob2_fp),
        ._0_f(_0_f), .fend(fend), .wdog(wdog)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] obs_out();
        return {f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp, strob2_fp, _0_f, fend, wdog};
    endfunction

    function automatic logic [13:0] exp_out(ph_t p, int t, logic wd);
        logic [6:0] lo;
        logic in_f;
        lo = 7'h7f;
        case (p)
            P_F2:  lo[6] = 1'b0;
            P_F4:  lo[5] = 1'b0;
            P_F5:  lo[4] = 1'b0;
            P_F6:  lo[3] = 1'b0;
            P_F7:  lo[2] = 1'b0;
            P_F8:  lo[1] = 1'b0;
            P_F10: lo[0] = 1'b0;
            default: ;
        endcase
        in_f = (p != P_IDLE) && (p != P_DONE);
        return {lo, p == P_F9, p == P_F13, in_f && (t == 1), in_f && (t == 2),
                p == P_F1, p == P_DONE, wd};
    endfunction

    function automatic ph_t model_next(ph_t p, in_t v, int ucnt, output logic wd);
        wd = 1'b0;
        if (p == P_F3) return P_DONE;
        if (WDOG_ON && (ucnt == WDOG_MAX)) wd = 1'b1;
        if (v.di || wd) return P_F3;
        case (p)
            P_F1:  return P_F2;
            P_F2:  return v.af_sf ? P_F5 : P_F4;
            P_F5:  return v.g ? P_F3 : P_F8;
            P_F8:  return v.fic ? P_F8 : P_F6;
            P_F4:  return v.fic ? P_F4 : (v.nrf ? P_F13 : P_F9);
            P_F9:  return P_F6;
            P_F6:  return P_F7;
            P_F7:  return P_F10;
            P_F10: return v.ws ? P_F6 : (v.ff ? P_F13 : P_F3);
            P_F13: return P_F3;
            default: return P_IDLE;
        endcase
    endfunction

    function automatic in_t mk(logic a, logic n, logic f, logic gg, logic fc, logic w, logic d);
        return {a, n, f, gg, fc, w, d};
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.af_sf = 1'($urandom_range(0, 1));
        v.nrf   = 1'($urandom_range(0, 1));
        v.ff    = 1'($urandom_range(0, 1));
        v.g     = 1'($urandom_range(0, 1));
        v.fic   = ($urandom_range(0, 2) == 0);
        v.ws    = ws_used ? 1'b0 : 1'($urandom_range(0, 1));
        v.di    = ($urandom_range(0, 11) == 0);
        return v;
    endfunction

    // Runs one instruction from IDLE through DONE and back to IDLE, checking every cycle
    task automatic run_instr(input string tag, output int lat);
        ph_t  p;
        in_t  v;
        logic wd_new;
        int   ucnt, n, hold;
        visited.delete();
        ws_used = 1'b0;
        puf = 1'b1;
        wait_edge();
        lat = 1;
        p = P_F1;
        ucnt = 0;
        wd_exp = 1'b0;
        n = 0;
        while (p != P_DONE && n < 60) begin
            v = (script.size() > 0) ? script.pop_front() : rand_in();
            {af_sf, nrf, ff, g, fic, ws, di} = v;
            visited.push_back(p);
            for (int t = 0; t < 3; t++) begin
                chk($sformatf("%s_%s_t%0d", tag, p.name(), t), 32'(obs_out()), 32'(exp_out(p, t, wd_exp)));
                wait_edge();
                lat++;
            end
            ucnt++;
            if (p == P_F10 && v.ws) ws_used = 1'b1;
            p = model_next(p, v, ucnt, wd_new);
            if (wd_new) wd_exp = 1'b1;
            n++;
        end
        chk({tag, "_reach_done"}, 32'(p == P_DONE), 32'd1);
        {af_sf, nrf, ff, g, fic, ws, di} = rand_in();
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            chk($sformatf("%s_done_%0d", tag, i), 32'(obs_out()), 32'(exp_out(P_DONE, 0, wd_exp)));
            if (i < hold - 1) wait_edge();
        end
        puf = 1'b0;
        wait_edge();
        chk({tag, "_idle"}, 32'(obs_out()), 32'(exp_out(P_IDLE, 0, wd_exp)));
    endtask

    task automatic cmp_seq(input string tag, input ph_t e[$]);
        chk({tag, "_len"}, 32'(visited.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < visited.size(); i++) begin
            chk($sformatf("%s_ph%0d", tag, i), 32'(visited[i]), 32'(e[i]));
        end
    endtask

    initial begin
        int lat;
        clr_ = 1'b0; puf = 1'b0;
        {af_sf, nrf, ff, g, fic, ws, di} = '0;
        wait_edge();
        wait_edge();
        chk("reset_out", 32'(obs_out()), 32'(exp_out(P_IDLE, 0, 1'b0)));
        clr_ = 1'b1;
        wait_edge();
        chk("idle_out", 32'(obs_out()), 32'(exp_out(P_IDLE, 0, 1'b0)));

        // Shortest path F1,F2,F5,F3
        repeat (4) script.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        run_instr("short", lat);
        chk("short_lat", lat, 13);
        cmp_seq("short", '{P_F1, P_F2, P_F5, P_F3});

`ifndef FPU_SEQ_WDOG_EN
        // F8 loop: four repeats, then F6,F7,F10,F13
        repeat (3) script.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        repeat (4) script.push_back(mk(1, 0, 1, 0, 1, 0, 0));
        repeat (6) script.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        run_instr("f8loop", lat);
        chk("f8loop_lat", lat, 40);
        cmp_seq("f8loop", '{P_F1, P_F2, P_F5, P_F8, P_F8, P_F8, P_F8, P_F8,
                            P_F6, P_F7, P_F10, P_F13, P_F3});

        // Multiply with one correction pass
        repeat (2) script.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        repeat (2) script.push_back(mk(0, 0, 1, 0, 1, 0, 0));
        repeat (4) script.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        script.push_back(mk(0, 0, 1, 0, 0, 1, 0));
        repeat (5) script.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        run_instr("mul", lat);
        chk("mul_lat", lat, 43);
        cmp_seq("mul", '{P_F1, P_F2, P_F4, P_F4, P_F4, P_F9, P_F6, P_F7,
                         P_F10, P_F6, P_F7, P_F10, P_F13, P_F3});
`endif

        // Interrupt during the first F8 micro-cycle
        repeat (3) script.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        script.push_back(mk(1, 0, 1, 0, 1, 0, 1));
        script.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        run_instr("intr", lat);
        chk("intr_lat", lat, 16);
        cmp_seq("intr", '{P_F1, P_F2, P_F5, P_F8, P_F3});

        // Reset in F4 tick1, with puf held high
        {af_sf, nrf, ff, g, fic, ws, di} = mk(0, 0, 0, 0, 1, 0, 0);
        puf = 1'b1;
        repeat (8) wait_edge();
        chk("rst_pre_f4t1", 32'(obs_out()), 32'(exp_out(P_F4, 1, 1'b0)));
        clr_ = 1'b0;
        wait_edge();
        chk("rst_out0", 32'(obs_out()), 32'(exp_out(P_IDLE, 0, 1'b0)));
        wait_edge();
        chk("rst_out1", 32'(obs_out()), 32'(exp_out(P_IDLE, 0, 1'b0)));
        clr_ = 1'b1;
        wait_edge();
        chk("rst_restart_f1", 32'(obs_out()), 32'(exp_out(P_F1, 0, 1'b0)));
        clr_ = 1'b0;
        puf = 1'b0;
        wait_edge();
        clr_ = 1'b1;
        wd_exp = 1'b0;
        wait_edge();
        chk("rst_idle", 32'(obs_out()), 32'(exp_out(P_IDLE, 0, 1'b0)));

`ifdef FPU_SEQ_WDOG_EN
        // fic stuck high in F8 until the watchdog fires
        repeat (10) script.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        run_instr("wdog", lat);
        chk("wdog_lat", lat, 28);
        chk("wdog_held", 32'(wdog), 32'd1);
        cmp_seq("wdog", '{P_F1, P_F2, P_F5, P_F8, P_F8, P_F8, P_F8, P_F8, P_F3});
        repeat (4) script.push_back(mk(1, 0, 0, 1, 0, 0, 0));
        run_instr("wdog_clr", lat);
`endif

        for (int i = 0; i < 30; i++) begin
            run_instr($sformatf("rnd%0d", i), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
